// File: rtl/data_4x4_row_loader_if.sv
// -----------------------------------------------------------------------------
// data_4x4_row_loader_if
//
// Purpose : Bundles the row-input and tile-output handshakes of the
//           4x4 row loader into one interface.
//
// Signals : in_valid  - producer presents a row on in_row
//           in_ready  - loader accepts a row this cycle
//           in_row    - one 4-element row, element 0 in the MSBs (4*W bits)
//           out_valid - out_data holds a complete tile
//           out_ready - consumer takes the tile this cycle
//           out_data  - 4x4 tile, row 0 in the MSBs (16*W bits)
//
// Modports: master - producer/consumer side (testbench or neighbouring stages)
//           slave  - the loader itself
// -----------------------------------------------------------------------------
interface data_4x4_row_loader_if #(
    parameter int W = 8
) ();

    logic              in_valid;
    logic              in_ready;
    logic [4*W-1:0]    in_row;
    logic              out_valid;
    logic              out_ready;
    logic [16*W-1:0]   out_data;

    modport master (
        output in_valid,
        output in_row,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_row,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/data_4x4_row_loader.sv
// -----------------------------------------------------------------------------
// data_4x4_row_loader
//
// Purpose : Packs four consecutive 4-element rows into one 4x4 tile and
//           presents it as a registered 16*W-bit word for data_4x4_transform.
//           Accepts one row per clock with no bubbles while the consumer is
//           ready; holds at most one tile in assembly and one in the output
//           register, and stalls the producer while a finished tile waits.
//
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous, active-high reset
//           bus  - data_4x4_row_loader_if.slave
//                  (in_valid/in_ready/in_row, out_valid/out_ready/out_data)
// -----------------------------------------------------------------------------
module data_4x4_row_loader #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    data_4x4_row_loader_if.slave   bus
);

    localparam int ROW_W  = 4 * W;
    localparam int TILE_W = 16 * W;

    // S_PEND: a complete tile sits in row0..row3 waiting for the output
    // register; the producer is stalled so rows 0..2 are not overwritten.
    typedef enum logic {
        S_FILL = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [1:0]          row_cnt;
    logic [ROW_W-1:0]    row0;
    logic [ROW_W-1:0]    row1;
    logic [ROW_W-1:0]    row2;
    logic [ROW_W-1:0]    row3;

    logic                out_valid_q;
    logic [TILE_W-1:0]   out_data_q;

    logic                in_fire;
    logic                out_free;
    logic                last_row;
    logic                load_direct;
    logic                load_pend;

    // in_ready depends only on state and rst, never on out_ready.
    assign bus.in_ready  = (state == S_FILL) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // -------------------------------------------------------------------------
    // Next-state and load decisions
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path leaves a signal unassigned, which would infer a latch.
        state_nxt   = state;
        in_fire     = bus.in_valid && bus.in_ready;
        out_free    = !out_valid_q || bus.out_ready;
        last_row    = in_fire && (row_cnt == 2'd3);
        // The two loads are exclusive: in S_PEND in_ready is 0, so no row fires.
        load_direct = last_row && out_free;
        load_pend   = (state == S_PEND) && out_free;

        case (state)
            S_FILL: if (last_row && !out_free) state_nxt = S_PEND;
            S_PEND: if (out_free)              state_nxt = S_FILL;
            default:                           state_nxt = S_FILL;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Row counter and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (in_fire) begin
                row_cnt <= row_cnt + 2'd1;   // 3 wraps to 0 naturally
            end

            if (load_direct) begin
                out_data_q  <= {row0, row1, row2, bus.in_row};
                out_valid_q <= 1'b1;
            end else if (load_pend) begin
                out_data_q  <= {row0, row1, row2, row3};
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;         // out_data keeps its last value
            end
        end
    end

    // -------------------------------------------------------------------------
    // Assembly buffer
    // -------------------------------------------------------------------------
    // NOTE: the row storage is deliberately not reset: its contents are only
    // read after row_cnt (which is reset) has walked over them again, so
    // clearing it would cost reset fan-out for no behavioural difference.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            case (row_cnt)
                2'd0:    row0 <= bus.in_row;
                2'd1:    row1 <= bus.in_row;
                2'd2:    row2 <= bus.in_row;
                default: if (!out_free) row3 <= bus.in_row;
            endcase
        end
    end

endmodule

// File: tb/tb_data_4x4_row_loader.sv
// -----------------------------------------------------------------------------
// tb_data_4x4_row_loader
//
// Purpose : Self-checking bench for data_4x4_row_loader. A row-packing model
//           pushes each expected tile into a queue when its 4th row is
//           handshaked; tiles are popped and compared when the DUT hands one
//           to the consumer. Feature tasks add cycle-exact inline checks.
//
// Ports   : none (top-level bench)
// -----------------------------------------------------------------------------
module tb_data_4x4_row_loader;

    localparam int W      = 8;
    localparam int ROW_W  = 4 * W;
    localparam int TILE_W = 16 * W;

    logic clk = 1'b0;
    logic rst;

    data_4x4_row_loader_if #(.W(W)) bus ();

    data_4x4_row_loader #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                 checks = 0;
    int                 errors = 0;

    logic [TILE_W-1:0]  exp_q[$];
    logic [TILE_W-1:0]  asm_tile;
    int                 asm_cnt;
    logic               last_acc;

    // One clock cycle: drive inputs just after a falling edge, sample the
    // handshakes before the rising edge, return at the next falling edge.
    task automatic step(input logic iv, input logic [ROW_W-1:0] row, input logic ordy);
        logic [TILE_W-1:0] exp;
        bus.in_valid  = iv;
        bus.in_row    = row;
        bus.out_ready = ordy;
        #1;
        last_acc = iv && (bus.in_ready === 1'b1);
        if (bus.out_valid === 1'b1 && ordy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_tile: got %h, required no tile", bus.out_data);
            end else begin
                exp = exp_q.pop_front();
                if (bus.out_data !== exp) begin
                    errors++;
                    $display("FAIL sb_tile: got %h, required %h", bus.out_data, exp);
                end
            end
        end
        if (last_acc) begin
            asm_tile = {asm_tile[TILE_W-ROW_W-1:0], row};
            asm_cnt++;
            if (asm_cnt == 4) begin
                exp_q.push_back(asm_tile);
                asm_cnt = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [ROW_W-1:0] rep(input logic [7:0] b);
        return {b, b, b, b};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
        rst = 1'b0;
        asm_cnt = 0;
        exp_q.delete();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_basic_pack();
        step(1'b1, 32'h01010101, 1'b1);
        step(1'b1, 32'h02020202, 1'b1);
        step(1'b1, 32'h03030303, 1'b1);
        step(1'b1, 32'h04040404, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pack_valid: got %b, required 1", bus.out_valid); end
        checks++;
        if (bus.out_data !== 128'h01010101020202020303030304040404) begin
            errors++; $display("FAIL pack_data: got %h, required %h", bus.out_data, 128'h01010101020202020303030304040404);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pack_valid_drop: got %b, required 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        logic exp_v;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b, required 1", i, bus.in_ready); end
            step(1'b1, rep(8'h11 * 8'(i + 1)), 1'b1);
            exp_v = (i == 3) || (i == 7);
            checks++;
            if (bus.out_valid !== exp_v) begin errors++; $display("FAIL stream_valid[%0d]: got %b, required %b", i, bus.out_valid, exp_v); end
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b, required 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [TILE_W-1:0] tile1;
        logic [TILE_W-1:0] tile2;
        tile1 = {rep(8'h21), rep(8'h22), rep(8'h23), rep(8'h24)};
        tile2 = {rep(8'h25), rep(8'h26), rep(8'h27), rep(8'h28)};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rep(8'h21 + 8'(i)), 1'b0);
            if (i == 3) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== tile1) begin
                    errors++; $display("FAIL bp_tile1: got v=%b %h, required v=1 %h", bus.out_valid, bus.out_data, tile1);
                end
            end
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b, required 0", bus.in_ready); end
        checks++;
        if (bus.out_data !== tile1) begin errors++; $display("FAIL bp_hold: got %h, required %h", bus.out_data, tile1); end
        step(1'b1, 32'hDEADBEEF, 1'b0);
        checks++;
        if (last_acc !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_row9_rejected: got acc=%b in_ready=%b, required 0 0", last_acc, bus.in_ready);
        end
        step(1'b1, 32'hDEADBEEF, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== tile2) begin
            errors++; $display("FAIL bp_tile2: got v=%b %h, required v=1 %h", bus.out_valid, bus.out_data, tile2);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b, required 1", bus.in_ready); end
        step(1'b0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b, required 0", bus.out_valid); end
    endtask

    task automatic test_simultaneous();
        logic [TILE_W-1:0] tile_b;
        tile_b = {rep(8'h41), rep(8'h42), rep(8'h43), rep(8'h44)};
        for (int i = 0; i < 4; i++) step(1'b1, rep(8'h31 + 8'(i)), 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready[%0d]: got %b, required 1", i, bus.in_ready); end
            step(1'b1, rep(8'h41 + 8'(i)), (i == 3));
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== tile_b) begin
            errors++; $display("FAIL simul_tile_b: got v=%b %h, required v=1 %h", bus.out_valid, bus.out_data, tile_b);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL simul_no_pend: got %b, required 1", bus.in_ready); end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [TILE_W-1:0] tile;
        tile = {rep(8'hAA), rep(8'hBB), rep(8'hCC), rep(8'hDD)};
        step(1'b1, rep(8'h51), 1'b1);
        step(1'b1, rep(8'h52), 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b, required 0", bus.in_ready); end
        step(1'b1, rep(8'h53), 1'b1);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got rdy=%b v=%b %h, required all 0", bus.in_ready, bus.out_valid, bus.out_data);
        end
        rst = 1'b0;
        asm_cnt = 0;
        step(1'b1, rep(8'hAA), 1'b1);
        step(1'b1, rep(8'hBB), 1'b1);
        step(1'b1, rep(8'hCC), 1'b1);
        step(1'b1, rep(8'hDD), 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== tile) begin
            errors++; $display("FAIL rstmid_tile: got v=%b %h, required v=1 %h", bus.out_valid, bus.out_data, tile);
        end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_gapped();
        int               accepted = 0;
        int               n = 0;
        logic             iv;
        logic             ordy;
        logic [ROW_W-1:0] row;
        while (accepted < 12 && n < 400) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            row  = iv ? {8'hC0, 8'(accepted), 16'h1234 ^ 16'(accepted * 37)} : $urandom;
            step(iv, row, ordy);
            if (last_acc) accepted++;
            n++;
        end
        checks++;
        if (accepted != 12) begin errors++; $display("FAIL gapped_timeout: got %0d rows, required 12", accepted); end
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            step(1'b0, $urandom, 1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL gapped_drain: got %0d tiles left, required 0", exp_q.size()); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gapped_idle: got %b, required 0", bus.out_valid); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;
        asm_tile      = '0;
        asm_cnt       = 0;
        last_acc      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_pack();
        test_streaming();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid();
        test_gapped();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d tiles left, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_4x4_row_loader.md
# data_4x4_row_loader

Upstream feeder for `data_4x4_transform`. Accepts a stream of 4-element rows over a valid/ready handshake, packs four consecutive rows into one 4x4 tile, and presents the tile as a registered `16*W`-bit word with valid/ready toward the transform stage. Sustains one row per clock with no bubbles while the consumer is ready. Stalls the producer cleanly under back-pressure.

## Interface
- `W`, 8, element width in bits. A row is `4*W` bits and a tile is `16*W` bits, so the defaults are 32 and 128.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer presents a row on `in_row`.
- `in_ready`  out  1  block accepts a row this cycle. A row transfers when `in_valid && in_ready`.
- `in_row`  in  4*W  one row; element 0 is in the MSBs.
- `out_valid`  out  1  `out_data` holds a complete tile.
- `out_ready`  in  1  consumer takes the tile. A tile transfers when `out_valid && out_ready`.
- `out_data`  out  16*W  tile in row-major order. Row 0 is `[16W-1:12W]` and row 3 is `[4W-1:0]`, which matches the `data` port layout of `data_4x4_transform`.

## Operation
- **Internal state**
  - 2-bit `row_cnt` (0..3).
  - Assembly buffer for rows 0..2, plus a row-3 holding slot.
  - `pend` flag: a complete tile is waiting for the output register.
  - Output register with `out_valid`.
- **`out_free`** is defined as `!out_valid || out_ready`.
- **Row accept with `row_cnt` < 3**
  - Store `in_row` into buffer slot `row_cnt`.
  - `row_cnt` increments.
- **Row accept with `row_cnt` == 3**
  - `row_cnt` wraps to 0.
  - If `out_free`: load `out_data` with {row0,row1,row2,`in_row`} and set `out_valid` to 1.
  - Otherwise: store `in_row` in the row-3 slot and set `pend` to 1.
- **`pend` == 1 and `out_free`**
  - Load `out_data` from the buffer plus the row-3 slot.
  - Set `out_valid` to 1 and clear `pend`.
- **`in_ready`** is `!pend && !rst`.
  - While `pend` is set, no new row is accepted. This protects buffer rows 0..2.
  - Therefore at most one tile is held in assembly and one in output.
- **Output register behaviour**
  - If `out_valid && out_ready` and no new tile is loading in that cycle, `out_valid` goes to 0.
  - `out_data` holds its last value; it is not cleared.
- **Simultaneous events**
  - Consumer takes the tile in the same cycle the 4th row arrives: the new tile loads directly. `out_valid` stays 1 with no gap.
  - `pend` set and the consumer takes the tile in the same cycle: the pending tile moves to output. `in_ready` returns to 1 the next cycle.
- **Input handshake rules**
  - `in_valid` is ignored while `in_ready` is 0.
  - Producer data need not be held stable except in handshake cycles.
- **Reset**
  - `row_cnt`, `pend`, `out_valid` and `out_data` are set to 0.
  - `in_ready` is 0 during reset and 1 in the first cycle after reset deasserts.
  - Reset mid-tile discards partial rows. The next accepted row becomes row 0.
- No arithmetic is performed. Width rules are exact; there is no padding or truncation.

## Timing
- Latency from the 4th-row handshake edge to `out_valid`: 1 clock, with `out_valid` high on the next cycle when `out_free`.
- Under back-pressure, the tile appears 1 clock after the first cycle in which `out_free` holds while `pend` is set.
- Throughput:
  - 1 row per clock.
  - 1 tile per 4 clocks sustained while `out_ready` is held at 1.
- All outputs are registered except `in_ready`, which is a combinational function of `pend` and `rst` only. It has no combinational path from `out_ready`.

## Test plan
- **Basic pack.** After reset, send rows 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404 on 4 consecutive cycles with `out_ready`=1.
  - `out_data` is 128'h01010101020202020303030304040404 with `out_valid`=1 exactly 1 cycle after the 4th row.
  - `out_valid` is 0 on the following cycle.
- **Streaming.** Send 8 back-to-back rows (0x11111111…0x88888888) with `out_ready`=1.
  - Two tiles appear 4 cycles apart.
  - `in_ready` stays 1 throughout.
- **Back-pressure.** Hold `out_ready`=0 and send 8 rows.
  - The first tile is held on `out_data`.
  - `in_ready` drops to 0 the cycle after the 8th row; a 9th row offered is not accepted.
  - Raise `out_ready` for 1 cycle: the second tile appears next cycle and `in_ready` returns to 1.
- **Simultaneous.** With tile A valid and `out_ready`=1 in the cycle the 4th row of tile B is accepted:
  - `out_valid` stays 1.
  - `out_data` switches to B the next cycle.
  - `pend` never sets.
- **Reset mid-operation.** Accept 2 rows, pulse `rst` for 1 cycle, then send 4 rows 0xA…, 0xB…, 0xC…, 0xD….
  - `out_data` is {A,B,C,D}, with no earlier rows present.
  - All outputs are 0 during reset.
- **Gapped input.** Drop `in_valid` randomly between rows while `in_row` carries garbage.
  - Tile content equals only the handshaked rows, in order.
